// File: rtl/dpseq_pkg.sv
// Shared types and constants for the datapath sequencer: state encoding,
// opcode values and bit positions inside the strobe vector.
package dpseq_pkg;

   localparam int OPCODE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T0   = 2'd1,
      T1   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LDA  = 2'b00;
   localparam logic [OPCODE_W-1:0] OP_MVAB = 2'b01;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 2'b10;
   localparam logic [OPCODE_W-1:0] OP_MVZB = 2'b11;

   localparam int STB_RAIN  = 0;
   localparam int STB_RBIN  = 1;
   localparam int STB_RZIN  = 2;
   localparam int STB_RAOUT = 3;
   localparam int STB_RBOUT = 4;
   localparam int STB_RZOUT = 5;
   localparam int STB_W     = 6;

   // ADD is the only operation that needs a second T-state.
   function automatic logic is_two_step(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADD);
   endfunction

endpackage

// File: rtl/dpseq_decode.sv
// Moore output decode for the datapath sequencer: (state, captured opcode)
// to the six datapath strobes and the retire pulse. Purely combinational.
module dpseq_decode
   import dpseq_pkg::*;
(
   input  state_t              state,
   input  logic [OPCODE_W-1:0] op_q,
   output logic [STB_W-1:0]    strb,
   output logic                done
);

   // Only one bus driver is ever selected per (state, op) pair.
   always_comb begin
      strb = '0;
      done = 1'b0;
      case (state)
         T0: begin
            case (op_q)
               OP_LDA: begin
                  strb[STB_RAIN] = 1'b1;
               end
               OP_MVAB: begin
                  strb[STB_RAOUT] = 1'b1;
                  strb[STB_RBIN]  = 1'b1;
               end
               OP_ADD: begin
                  strb[STB_RAOUT] = 1'b1;
                  strb[STB_RZIN]  = 1'b1;
               end
               default: begin
                  strb[STB_RZOUT] = 1'b1;
                  strb[STB_RBIN]  = 1'b1;
               end
            endcase
         end
         T1: begin
            if (op_q == OP_ADD) begin
               strb[STB_RZOUT] = 1'b1;
               strb[STB_RBIN]  = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Control sequencer for the 8-bit RA/RB/RZ bus datapath. Accepts one
// operation per start/done handshake and sequences load enables and bus
// drive selects over one or two T-states.
// Optional build macro DATAPATH_SEQ_OPCOUNT_EN adds the 8-bit op_count
// output, counting retired operations (wraps silently).
//
// state | meaning
// IDLE  | waiting for start; op captured on acceptance
// T0    | first T-state of the captured operation
// T1    | second T-state, ADD only (RZ -> RB)
// DONE  | operation retired, done pulse, start ignored
module datapath_sequencer
   import dpseq_pkg::*;
#(
   parameter int OPW = OPCODE_W
) (
   input  logic           clock,
   input  logic           clear,
   input  logic           start,
   input  logic [OPW-1:0] op,
   output logic           busy,
   output logic           done,
   output logic           RAin,
   output logic           RBin,
   output logic           RZin,
   output logic           RAout,
   output logic           RBout,
   output logic           RZout
`ifdef DATAPATH_SEQ_OPCOUNT_EN
   ,
   output logic [7:0]     op_count
`endif
);

   state_t               state;
   state_t               state_nxt;
   logic [OPCODE_W-1:0]  op_q;
   logic [STB_W-1:0]     strb;
   logic                 dec_done;

   // State and captured opcode; op_q only loads when a start is accepted.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         op_q  <= OP_LDA;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start)
            op_q <= op[OPCODE_W-1:0];
      end
   end

   // Next-state: start only matters in IDLE, DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? T0 : IDLE;
         T0:      state_nxt = is_two_step(op_q) ? T1 : DONE;
         T1:      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   dpseq_decode u_decode (
      .state (state),
      .op_q  (op_q),
      .strb  (strb),
      .done  (dec_done)
   );

   // Output process: fan the strobe vector out to the datapath ports.
   always_comb begin
      busy  = (state != IDLE);
      done  = dec_done;
      RAin  = strb[STB_RAIN];
      RBin  = strb[STB_RBIN];
      RZin  = strb[STB_RZIN];
      RAout = strb[STB_RAOUT];
      RBout = strb[STB_RBOUT];
      RZout = strb[STB_RZOUT];
   end

`ifdef DATAPATH_SEQ_OPCOUNT_EN
   // Retired-operation counter, one increment per done pulse, free wrap.
   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         op_count <= 8'd0;
      else if (state == DONE)
         op_count <= op_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: per-cycle comparison against a queue-based
// model of the operation schedule, plus a small datapath model for the
// register-transfer scenarios.
module tb_datapath_sequencer;

   localparam logic [6:0] E_DONE  = 7'b1000000;
   localparam logic [6:0] E_RAIN  = 7'b0100000;
   localparam logic [6:0] E_RBIN  = 7'b0010000;
   localparam logic [6:0] E_RZIN  = 7'b0001000;
   localparam logic [6:0] E_RAOUT = 7'b0000100;
   localparam logic [6:0] E_RZOUT = 7'b0000001;

   logic       clock = 1'b0;
   logic       clear;
   logic       start;
   logic [1:0] op;
   logic       busy, done;
   logic       RAin, RBin, RZin, RAout, RBout, RZout;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
   logic [7:0] op_count;
`endif

   int checks = 0;
   int errors = 0;
   int accepted = 0;
   int obs_dones = 0;
   logic [6:0] q[$];
   logic [7:0] exp_count = 8'd0;

   logic [7:0] dp_ra = 8'd0, dp_rb = 8'd0, dp_rz = 8'd0;
   logic [7:0] dp_a = 8'd0, dp_imm = 8'd0;
   logic [7:0] bus;

   always #5 clock = ~clock;

   datapath_sequencer dut (
      .clock (clock),
      .clear (clear),
      .start (start),
      .op    (op),
      .busy  (busy),
      .done  (done),
      .RAin  (RAin),
      .RBin  (RBin),
      .RZin  (RZin),
      .RAout (RAout),
      .RBout (RBout),
      .RZout (RZout)
`ifdef DATAPATH_SEQ_OPCOUNT_EN
      ,
      .op_count (op_count)
`endif
   );

   // Datapath model: immediate appears on the bus when nobody drives it.
   always_comb begin
      if (RAout)      bus = dp_ra;
      else if (RZout) bus = dp_rz;
      else if (RBout) bus = dp_rb;
      else            bus = dp_imm;
   end

   always @(posedge clock) begin
      if (RAin) dp_ra <= bus;
      if (RBin) dp_rb <= bus;
      if (RZin) dp_rz <= dp_a + bus;
   end

   task automatic cycle();
      logic [6:0] exp_v, obs_v;
      int nout;
      @(negedge clock);
      exp_v = (q.size() == 0) ? 7'd0 : q[0];
      obs_v = {done, RAin, RBin, RZin, RAout, RBout, RZout};
      nout  = int'(RAout) + int'(RBout) + int'(RZout);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL strobes t=%0t observed=%b expected=%b", $time, obs_v, exp_v);
      end
      checks++;
      assert (busy === (q.size() != 0)) else begin
         errors++;
         $error("FAIL busy t=%0t observed=%b expected=%b", $time, busy, (q.size() != 0));
      end
      checks++;
      assert ((nout <= 1) === 1'b1) else begin
         errors++;
         $error("FAIL bus_excl t=%0t observed=%0d expected<=1", $time, nout);
      end
`ifdef DATAPATH_SEQ_OPCOUNT_EN
      checks++;
      assert (op_count === exp_count) else begin
         errors++;
         $error("FAIL op_count t=%0t observed=%0d expected=%0d", $time, op_count, exp_count);
      end
`endif
      if (done === 1'b1) obs_dones++;
      if (q.size() == 0) begin
         if (start === 1'b1) begin
            accepted++;
            case (op)
               2'b00:   begin q.push_back(E_RAIN);            q.push_back(E_DONE); end
               2'b01:   begin q.push_back(E_RAOUT | E_RBIN);  q.push_back(E_DONE); end
               2'b10:   begin q.push_back(E_RAOUT | E_RZIN);  q.push_back(E_RZOUT | E_RBIN);
                              q.push_back(E_DONE); end
               default: begin q.push_back(E_RZOUT | E_RBIN);  q.push_back(E_DONE); end
            endcase
         end
      end else begin
         if (q[0] == E_DONE) exp_count = exp_count + 8'd1;
         void'(q.pop_front());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      logic [7:0] obs_v;
      obs_v = {busy, done, RAin, RBin, RZin, RAout, RBout, RZout};
      checks++;
      assert (obs_v === 8'd0) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs_v, 8'd0);
      end
   endtask

   task automatic do_reset();
      #2 clear = 1'b1;
      #1 check_quiet("reset_outputs");
      q.delete();
      exp_count = 8'd0;
      @(negedge clock);
      clear = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic run_op(input logic [1:0] o);
      op = o;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic check_rb(input string tag, input logic [7:0] exp_v);
      checks++;
      assert (dp_rb === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, dp_rb, exp_v);
      end
   endtask

   initial begin
      clear = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      #12 check_quiet("power_on_reset");
      @(negedge clock);
      clear = 1'b0;
      @(posedge clock);
      #1;
      repeat (2) cycle();

      // LDA 2A then MVAB
      dp_imm = 8'h2A;
      run_op(2'b00);
      run_op(2'b01);
      check_rb("mvab_rb", 8'h2A);

      // ADD 05 + 03
      dp_imm = 8'h05;
      run_op(2'b00);
      dp_a = 8'h03;
      run_op(2'b10);
      check_rb("add_rb_08", 8'h08);

      // ADD with carry discarded: FF + 02
      dp_imm = 8'h02;
      run_op(2'b00);
      dp_a = 8'hFF;
      run_op(2'b10);
      check_rb("add_rb_wrap", 8'h01);

      // clear while ADD is in T1
      op = 2'b10;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      checks++;
      assert ({RZout, RBin} === 2'b11) else begin
         errors++;
         $error("FAIL pre_clear_t1 observed=%b expected=%b", {RZout, RBin}, 2'b11);
      end
      do_reset();
      repeat (3) cycle();

      // start held high with MVZB: one done every third cycle
      obs_dones = 0;
      op = 2'b11;
      start = 1'b1;
      repeat (30) cycle();
      start = 1'b0;
      checks++;
      assert (obs_dones === 10) else begin
         errors++;
         $error("FAIL held_start_dones observed=%0d expected=%0d", obs_dones, 10);
      end
      repeat (3) cycle();

      // random start/op
      obs_dones = 0;
      accepted  = 0;
      for (int i = 0; i < 10000; i++) begin
         start = 1'($urandom_range(0, 1));
         op    = 2'($urandom_range(0, 3));
         cycle();
      end
      start = 1'b0;
      repeat (4) cycle();
      checks++;
      assert (obs_dones === accepted) else begin
         errors++;
         $error("FAIL random_done_count observed=%0d expected=%0d", obs_dones, accepted);
      end

`ifdef DATAPATH_SEQ_OPCOUNT_EN
      do_reset();
      for (int i = 0; i < 256; i++) begin
         op = 2'b00;
         start = 1'b1;
         cycle();
         start = 1'b0;
         repeat (2) cycle();
      end
      cycle();
      checks++;
      assert (op_count === 8'd0) else begin
         errors++;
         $error("FAIL op_count_wrap observed=%0d expected=%0d", op_count, 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Control sequencer for the 8-bit bus datapath (RA, RB, RZ registers, adder, shared bus mux). It accepts one operation at a time through a start/done handshake and drives the register load enables (RAin, RBin, RZin) and bus drive selects (RAout, RBout, RZout) over one or two T-states, so the operation completes without bus contention. It sits beside the datapath and is the only source of its control strobes.

## Interface
Parameters:
- OPW, 2, opcode width (fixed encoding; not intended to change)

Ports (reset is asynchronous, active-high):
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  OPW  operation, captured with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when an operation retires
- RAin, RBin, RZin  out  1 each  register load enables to datapath
- RAout, RBout, RZout  out  1 each  bus drive selects; at most one high per cycle

## Operation
- Opcodes:
  - 00 LDA: load immediate into RA.
  - 01 MVAB: RB <= RA.
  - 10 ADD: RZ <= A + RA, then RB <= RZ.
  - 11 MVZB: RB <= RZ.
- States: IDLE, T0, T1, DONE; binary encoded; op_q register.
- Transitions:
  - IDLE -> T0 when start=1, with op_q <= op.
  - T0 -> T1 if op_q=ADD, else T0 -> DONE.
  - T1 -> DONE.
  - DONE -> IDLE unconditionally.
- Strobes (Moore decode of state, op_q; all others 0):
  - T0, LDA: RAin.
  - T0, MVAB: RAout, RBin.
  - T0, ADD: RAout, RZin.
  - T1, ADD: RZout, RBin.
  - T0, MVZB: RZout, RBin.
- IDLE and DONE drive all strobes 0; done=1 only in DONE.
- start while busy=1: ignored; not queued. op changes while busy: no effect (op_q held).
- No arithmetic in block; adder width (8-bit, carry discarded) belongs to datapath.

## Timing
- Reset: state=IDLE, op_q=00, busy=0, done=0, all six strobes 0, immediately on clear rising and held while clear=1.
- Latency start-to-done:
  - LDA, MVAB, MVZB: start sampled at edge k; strobes active cycle k+1; done high cycle k+2.
  - ADD: strobes cycles k+1 and k+2; done cycle k+3.
- Earliest next start: asserted during DONE cycle is ignored; first accepted in the cycle after done (IDLE).
- Back-to-back throughput: 3 cycles per single-step op, 4 per ADD.
- clear mid-operation (any of T0/T1/DONE): strobes drop asynchronously; the partial operation is abandoned and no done pulse is issued. After ADD T0 only, RZ may hold a partial result; this is not architectural state.
- Bus exclusivity invariant: RAout+RBout+RZout <= 1 every cycle, including reset.

## Configuration
- DATAPATH_SEQ_OPCOUNT_EN:
  - Defined: adds output op_count (8 bits), cleared by clear and incremented once per done pulse. It wraps 255 -> 0 with no flag.
  - Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package dpseq_pkg:
  - state enum (IDLE, T0, T1, DONE).
  - Opcode constants OP_LDA, OP_MVAB, OP_ADD, OP_MVZB.
  - Strobe vector field indices.
- One sub-module, dpseq_decode: pure combinational map (state, op_q) -> six strobes plus done. Top holds state and op_q registers and the optional counter.

## Test plan
- Reset: assert clear mid-ADD at T1 -> all strobes 0 same cycle, busy=0, no done; after release, IDLE, op_count=0 if enabled.
- LDA then MVAB: start op=00 -> RAin one cycle, done 2 cycles after start; then op=01 -> RAout+RBin one cycle; datapath with immediate 8'h2A gives RB=8'h2A.
- ADD: RA=8'h05, A=8'h03, start op=10 -> cycle1 RAout+RZin, cycle2 RZout+RBin, done cycle3; RB=8'h08. A=8'hFF, RA=8'h02 -> RB=8'h01.
- start held high continuously with op=11 -> done every 3rd cycle; start during DONE is not accepted early.
- Random op/start for 10k cycles -> bus exclusivity holds every cycle; done count equals accepted starts.
- With DATAPATH_SEQ_OPCOUNT_EN: 256 LDAs -> op_count wraps to 0.
